// File: rtl/gb_sound_pkg.sv
// Shared definitions for the sound channels: volume codes, length limit,
// wave channel state encoding and the frequency-code to period conversion.
package gb_sound_pkg;

    localparam logic [1:0] VOL_MUTE    = 2'd0;
    localparam logic [1:0] VOL_FULL    = 2'd1;
    localparam logic [1:0] VOL_HALF    = 2'd2;
    localparam logic [1:0] VOL_QUARTER = 2'd3;

    localparam int LEN_MAX  = 256;
    localparam int PERIOD_W = 13;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } wave_state_e;

    // (2048 - f) * 2 written as 4096 - 2f so it fits 13 bits for every code.
    function automatic logic [PERIOD_W-1:0] freq_to_period(input logic [10:0] f);
        return 13'd4096 - {1'b0, f, 1'b0};
    endfunction

    function automatic logic [3:0] vol_shift(input logic [3:0] s, input logic [1:0] v);
        logic [3:0] r;
        case (v)
            VOL_MUTE:    r = 4'd0;
            VOL_FULL:    r = s;
            VOL_HALF:    r = s >> 1;
            VOL_QUARTER: r = s >> 2;
            default:     r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wave_channel_if.sv
// Register/stimulus bundle between the register file and the wave channel,
// plus the channel's sample and status back to the mixer side.
interface wave_channel_if #(
    parameter int TABLE_DEPTH = 32,
    parameter int LEN_BITS    = 8
);
    logic                     clk256;
    logic                     dacEnable;
    logic [LEN_BITS-1:0]      lenLoad;
    logic [1:0]               vol;
    logic [10:0]              freq;
    logic                     trigger;
    logic                     lenEnable;
    logic [4*TABLE_DEPTH-1:0] waveTable;
    logic [3:0]               out;
    logic                     active;

    modport master (
        output clk256, dacEnable, lenLoad, vol, freq, trigger, lenEnable, waveTable,
        input  out, active
    );

    modport slave (
        input  clk256, dacEnable, lenLoad, vol, freq, trigger, lenEnable, waveTable,
        output out, active
    );
endinterface

// File: rtl/wave_channel_freq_timer.sv
// Loadable down-counter that paces wave table steps; pulses expire for one
// cycle when the count reaches 1 and reloads itself on that same cycle.
module wave_freq_timer
    import gb_sound_pkg::*;
#(
    parameter int W = PERIOD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] reload,
    output logic         expire
);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = W'(0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load strobe overrides counting and suppresses expiry.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (load) begin
            cnt_d = reload;
        end else if (en) begin
            if (cnt_q == ONE) begin
                expire = 1'b1;
                cnt_d  = reload;
            end else if (cnt_q != ZERO) begin
                cnt_d = cnt_q - ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wave_channel.sv
// Game Boy channel 3: steps through a 32 x 4-bit wave table at a programmable
// pitch, with volume shift, length timer and DAC power gating.
module wave_channel
    import gb_sound_pkg::*;
#(
    parameter int TABLE_DEPTH = 32,
    parameter int LEN_BITS    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    wave_channel_if.slave  bus
);
    localparam int POS_W = $clog2(TABLE_DEPTH);
    localparam int LEN_W = LEN_BITS + 1;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(1) << LEN_BITS;
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    wave_state_e        state_q,  state_d;
    logic [POS_W-1:0]   pos_q,    pos_d;
    logic [3:0]         sample_q, sample_d;
    logic [LEN_W-1:0]   len_q,    len_d;
    logic [3:0]         out_q,    out_d;
    logic               trig_q,   clk256_q, primed_q;

    logic               trig_rise_s;
    logic               tick_s;
    logic [POS_W-1:0]   pos_next_s;
    logic [3:0]         first_sample_s;
    logic [3:0]         next_sample_s;
    logic [LEN_W-1:0]   len_load_s;
    logic               timer_load_s;
    logic               timer_expire_s;

    // Edges only count once the detect flops have seen a real level after reset,
    // so a trigger held high across reset release is not a restart.
    assign trig_rise_s    = primed_q & bus.trigger & ~trig_q;
    assign tick_s         = primed_q & bus.clk256 & ~clk256_q;
    assign pos_next_s     = pos_q + POS_W'(1);
    assign first_sample_s = bus.waveTable[3:0];
    assign next_sample_s  = bus.waveTable[{pos_next_s, 2'b00} +: 4];
    assign len_load_s     = LEN_FULL - {1'b0, bus.lenLoad};

    wave_freq_timer #(.W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == PLAY),
        .load   (timer_load_s),
        .reload (freq_to_period(bus.freq)),
        .expire (timer_expire_s)
    );

    // Channel FSM, table position, length counter and output staging.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        sample_d     = sample_q;
        len_d        = len_q;
        timer_load_s = 1'b0;

        if (tick_s && bus.lenEnable && (len_q != LEN_ZERO)) begin
            len_d = len_q - LEN_ONE;
        end else begin
            len_d = len_q;
        end

        case (state_q)
            IDLE: begin
                if (trig_rise_s && bus.dacEnable) begin
                    state_d      = PLAY;
                    pos_d        = {POS_W{1'b0}};
                    sample_d     = first_sample_s;
                    len_d        = len_load_s;
                    timer_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                if (!bus.dacEnable) begin
                    state_d = IDLE;
                end else if (trig_rise_s) begin
                    state_d      = PLAY;
                    pos_d        = {POS_W{1'b0}};
                    sample_d     = first_sample_s;
                    len_d        = len_load_s;
                    timer_load_s = 1'b1;
                end else begin
                    if (timer_expire_s) begin
                        pos_d    = pos_next_s;
                        sample_d = next_sample_s;
                    end else begin
                        pos_d    = pos_q;
                        sample_d = sample_q;
                    end
                    if (bus.lenEnable && (len_d == LEN_ZERO)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output trails the sample register by a cycle and is silenced on the
        // cycle the channel starts or stops.
        if ((state_q == PLAY) && (state_d == PLAY)) begin
            out_d = vol_shift(sample_q, bus.vol);
        end else begin
            out_d = 4'd0;
        end
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pos_q    <= {POS_W{1'b0}};
            sample_q <= 4'd0;
            len_q    <= LEN_ZERO;
            out_q    <= 4'd0;
            trig_q   <= 1'b0;
            clk256_q <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            sample_q <= sample_d;
            len_q    <= len_d;
            out_q    <= out_d;
            trig_q   <= bus.trigger;
            clk256_q <= bus.clk256;
            primed_q <= 1'b1;
        end
    end

    assign bus.out    = out_q;
    assign bus.active = (state_q == PLAY);
endmodule

// File: tb/tb_wave_channel.sv
// Directed bench for wave_channel: pitch stepping, volume, length, DAC gating,
// retrigger/tick priority and reset behaviour against hand-derived values.
module tb_wave_channel;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wave_channel_if #(.TABLE_DEPTH(32), .LEN_BITS(8)) bus ();

    wave_channel #(.TABLE_DEPTH(32), .LEN_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         n     = 0;
    int         per   = 2;
    logic [3:0] tbl [32];

    function automatic logic [3:0] vol_model(input logic [3:0] s, input logic [1:0] v);
        if (v == 2'd0) return 4'd0;
        return s >> (v - 2'd1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step and compare out against the sample the position should hold n cycles after the trigger.
    task automatic play_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            step();
            n++;
            check(tag, 32'(bus.out), 32'(vol_model(tbl[((n - 1) / per) % 32], bus.vol)));
        end
    endtask

    task automatic retrigger();
        bus.trigger = 1'b0;
        step();
        bus.trigger = 1'b1;
        step();
        n = 0;
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.clk256    = 1'b0;
        bus.dacEnable = 1'b1;
        bus.lenLoad   = 8'd0;
        bus.vol       = 2'd1;
        bus.freq      = 11'd2047;
        bus.trigger   = 1'b0;
        bus.lenEnable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tbl[i] = (i < 16) ? 4'(i) : ((i == 16) ? 4'd0 : 4'(32 - i));
            bus.waveTable[4*i +: 4] = tbl[i];
        end

        #2 rst_n = 1'b0;
        #1;
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_active", 32'(bus.active), 32'd0);

        // Triangle at the fastest pitch
        bus.trigger = 1'b1;
        step();
        n = 0;
        check("trig_active", 32'(bus.active), 32'd1);
        check("trig_out", 32'(bus.out), 32'd0);
        play_check(70, "tri_v1");
        check("tri_active", 32'(bus.active), 32'd1);

        bus.vol = 2'd2;
        play_check(40, "tri_v2");
        bus.vol = 2'd3;
        play_check(64, "tri_v3");
        bus.vol = 2'd0;
        play_check(10, "tri_v0");
        check("mute_active", 32'(bus.active), 32'd1);

        // Length expiry after four ticks
        bus.vol       = 2'd1;
        bus.lenLoad   = 8'd252;
        bus.lenEnable = 1'b1;
        retrigger();
        check("len_trig_active", 32'(bus.active), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            bus.clk256 = 1'b1;
            step();
            check("len_tick_active", 32'(bus.active), 32'(i < 4));
            if (i == 4) check("len_end_out", 32'(bus.out), 32'd0);
            bus.clk256 = 1'b0;
            step();
        end

        bus.lenEnable = 1'b0;
        retrigger();
        for (int i = 0; i < 10; i++) begin
            bus.clk256 = 1'b1;
            step();
            bus.clk256 = 1'b0;
            step();
        end
        check("len_off_active", 32'(bus.active), 32'd1);

        // DAC power gating
        bus.dacEnable = 1'b0;
        step();
        check("dac_drop_active", 32'(bus.active), 32'd0);
        check("dac_drop_out", 32'(bus.out), 32'd0);
        retrigger();
        step();
        check("dac_off_active", 32'(bus.active), 32'd0);
        check("dac_off_out", 32'(bus.out), 32'd0);
        bus.dacEnable = 1'b1;
        retrigger();
        check("dac_on_active", 32'(bus.active), 32'd1);
        play_check(6, "dac_on_out");

        // Slow pitch, table edit and mid-step retrigger
        bus.freq = 11'd1024;
        retrigger();
        per = 2048;
        play_check(2050, "f1024");
        bus.waveTable[3:0] = 4'd9;
        play_check(1, "tbl_hold");
        retrigger();
        tbl[0] = 4'd9;
        play_check(2049, "retrig");

        // Trigger coincident with a length tick loads without decrementing
        bus.lenEnable = 1'b1;
        bus.lenLoad   = 8'd250;
        bus.trigger   = 1'b0;
        step();
        bus.trigger = 1'b1;
        bus.clk256  = 1'b1;
        step();
        check("coinc_active", 32'(bus.active), 32'd1);
        bus.clk256 = 1'b0;
        step();
        for (int i = 1; i <= 6; i++) begin
            bus.clk256 = 1'b1;
            step();
            check("coinc_len", 32'(bus.active), 32'(i < 6));
            bus.clk256 = 1'b0;
            step();
        end

        // Asynchronous reset mid-play with trigger held high
        bus.lenEnable = 1'b0;
        retrigger();
        check("pre_rst_active", 32'(bus.active), 32'd1);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(bus.out), 32'd0);
        check("async_rst_active", 32'(bus.active), 32'd0);
        #3 rst_n = 1'b1;
        repeat (5) step();
        check("no_restart_active", 32'(bus.active), 32'd0);
        check("no_restart_out", 32'(bus.out), 32'd0);
        retrigger();
        check("post_rst_active", 32'(bus.active), 32'd1);
        play_check(1, "post_rst_out");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wave_channel.md
Name: wave_channel

Overview:
- Game Boy channel 3 (programmable wave) voice.
- Plays a 32-entry x 4-bit wave table at a register-controlled pitch, applies a 2-bit volume shift and a length timer, and emits a 4-bit sample.
- Sits directly upstream of the mixer and drives its wave input, which is currently tied to 4'd0.
- Register inputs come from the per-time-step stimulus arrays (w_freq, w_vol, w_lenLoad, w_trigger, w_lenEnable), like the other channels.

Parameters:
- TABLE_DEPTH, 32, number of 4-bit wave samples; position counter width is clog2(TABLE_DEPTH).
- LEN_BITS, 8, width of lenLoad; the length counter is LEN_BITS+1 bits and counts up to 2^LEN_BITS (256).

Ports:
- clk  in  1  4.194304 MHz system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk256  in  1  256 Hz length strobe level from the frame timer; sampled on clk, rising edge detected internally, never used as a clock.
- dacEnable  in  1  NR30 bit 7; 0 powers the channel off.
- lenLoad  in  8  length load; run length is 256 - lenLoad ticks.
- vol  in  2  output level code: 0 mute, 1 100%, 2 50%, 3 25%.
- freq  in  11  frequency code.
- trigger  in  1  level; a rising edge (re)starts the channel.
- lenEnable  in  1  1 lets length ticks decrement the length counter.
- waveTable  in  128  flattened table; sample i = waveTable[4*i+3:4*i]; sample 0 plays first.
- out  out  4  channel sample to the mixer.
- active  out  1  channel-enabled status (NR52 bit 2).

Behaviour:
- Reset (async, rst_n=0): out=0, active=0, state IDLE, position=0, sample register=0, length counter=0, frequency timer=0, edge-detect flops=0.
- States:
  - IDLE: not enabled.
  - PLAY: enabled.
- IDLE->PLAY: trigger rising edge while dacEnable=1. With dacEnable=0 the trigger is ignored and the channel stays IDLE.
- PLAY->IDLE: length counter reaches 0 with lenEnable=1, or dacEnable falls to 0. Takes effect in the same cycle the condition is registered.
- PLAY->PLAY: a trigger rising edge while in PLAY restarts the channel.
- Trigger actions, all applied in one cycle:
  - position <= 0
  - sample <= waveTable sample 0
  - frequency timer <= (2048 - freq) * 2
  - length counter <= 256 - lenLoad (9-bit; lenLoad=0 gives 256)
- Frequency timer, PLAY only:
  - decrements every clk.
  - On the cycle it equals 1 it reloads (2048 - freq) * 2, position <= position + 1 (wraps 31->0), and sample <= the new position's entry.
  - Step period = (2048 - freq) * 2 clk cycles; freq=2047 gives 2 cycles per step.
  - A freq change takes effect at the next reload only.
- Length:
  - On a clk256 rising edge with lenEnable=1 and counter > 0: decrement.
  - If the decrement reaches 0: active falls the next cycle.
  - lenEnable=0: counter holds and the channel plays indefinitely.
  - A length tick in IDLE is a no-op apart from the decrement rule.
- Simultaneous trigger and length tick: the trigger wins; the counter loads and no decrement occurs that cycle.
- Simultaneous trigger and timer expiry: the trigger wins.
- Output is registered, one cycle after the sample register:
  - out = PLAY ? (vol==0 ? 0 : sample >> (vol - 1)) : 0
  - 4-bit logical shift, no rounding.
- active = (state == PLAY).
- waveTable is read combinationally at the indexed position. Table changes during PLAY affect the next loaded sample only.
- Reset asserted mid-play returns to the reset values immediately, regardless of clk. After release the channel stays IDLE until a fresh trigger rising edge.
  - A trigger held high through reset release does not count as an edge, because the edge flop resets to 0 and sees the level on the first cycle.

Decomposition:
- Shared package gb_sound_pkg:
  - volume code constants VOL_MUTE=0, VOL_FULL=1, VOL_HALF=2, VOL_QUARTER=3
  - LEN_MAX=256
  - wave state enum {IDLE, PLAY}
  - the freq-to-period function (2048 - f) * 2, also reusable by the pulse channels.
- One sub-module, wave_freq_timer: loadable down-counter with reload value input, load strobe, and one-cycle expiry pulse output. The position counter, length logic and FSM stay in wave_channel.

Test Plan:
- Triangle table (samples 0..15 then 0,15,14..1), vol=1, freq=2047, dacEnable=1, trigger 0->1 -> out steps 0,1,2,...,15,0,15,14,... every 2 clk; the full cycle repeats every 64 clk; active=1.
- Same setup, vol=2 then vol=3 -> sample 15 appears as 7 and then 3; vol=0 -> out stays 0 while active stays 1.
- lenLoad=252, lenEnable=1, trigger, then 4 clk256 rising edges -> active=0 and out=0 one cycle after the 4th edge; with lenEnable=0 the channel is still active after 10 edges.
- dacEnable=0 with a trigger edge -> active stays 0 and out=0; set dacEnable=1 and trigger again -> plays; drop dacEnable mid-play -> active=0 and out=0 the next cycle.
- freq=1024 (period 2048 clk), retrigger mid-step -> position restarts at 0 and out=sample 0; a trigger coincident with a clk256 edge loads the counter with no decrement.
- rst_n pulsed low mid-play with trigger held high -> out=0 and active=0 immediately; no restart after release until trigger goes 0->1.
